// File: rtl/clk_div_ctrl.sv
// Programmable clock divider (D = 2..15, 50% duty) with a request/ack
// controller that swaps the divisor only at output period boundaries.
module clk_div_ctrl (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       enable,
  input  logic       div_req,
  input  logic [3:0] div_value,
  output logic       div_ack,
  output logic       div_err,
  output logic       div_busy,
  output logic [3:0] div_active,
  output logic       clock_out_div,
  output logic       period_tick,
  output logic       dbg_state_o
);

  // Handshake: div_req is sampled on every posedge; while busy it is ignored.
  // An accepted request is answered by exactly one div_ack pulse, a rejected
  // one by exactly one div_err pulse, each in the cycle after the deciding edge.
  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] d_q, d_d;
  logic [3:0] pend_q, pend_d;
  logic       run_q, run_d;
  logic       p_q, p_d;
  logic       n_q;
  logic       ack_q, ack_d;
  logic       err_q, err_d;
  logic       last, boundary, apply;
  logic [4:0] half_d;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    err_d   = 1'b0;

    // Not running means cnt is parked at 0, which always counts as a boundary.
    last     = run_q && (cnt_q == d_q - 4'd1);
    boundary = last || !run_q;
    apply    = (state_q == PENDING) && boundary;
    ack_d    = apply;
    d_d      = apply ? pend_q : d_q;

    case (state_q)
      IDLE: begin
        if (div_req) begin
          if (div_value >= 4'd2) begin
            pend_d  = div_value;
            state_d = PENDING;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PENDING: begin
        if (apply) state_d = IDLE;
      end
    endcase

    // enable is only looked at when a period ends, so periods always complete.
    if (!run_q || last) begin
      cnt_d = 4'd0;
      run_d = enable;
    end else begin
      cnt_d = cnt_q + 4'd1;
      run_d = 1'b1;
    end

    half_d = ({1'b0, d_d} + 5'd1) >> 1;
    p_d    = run_d && ({1'b0, cnt_d} < half_d);
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      d_q     <= 4'd2;
      pend_q  <= 4'd0;
      run_q   <= 1'b0;
      p_q     <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      pend_q  <= pend_d;
      run_q   <= run_d;
      p_q     <= p_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Half-cycle delayed copy of p; ANDing it in trims odd divisors to D/2 high.
  always_ff @(negedge clock_in or posedge reset) begin
    if (reset) n_q <= 1'b0;
    else       n_q <= p_q;
  end

  assign clock_out_div = d_q[0] ? (p_q & n_q) : p_q;
  assign period_tick   = (cnt_q == d_q - 4'd1) && enable;
  assign div_ack       = ack_q;
  assign div_err       = err_q;
  assign div_busy      = (state_q == PENDING);
  assign div_active    = d_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios plus random requests/enable,
// compared against a half-cycle waveform model of the divider.
module tb_clk_div_ctrl;

  logic       clock_in = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       div_req = 1'b0;
  logic [3:0] div_value = 4'd0;
  logic       div_ack, div_err, div_busy, clock_out_div, period_tick, dbg_state_o;
  logic [3:0] div_active;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: divisor, position within the output period, pending request.
  int m_d, m_pos, m_pend;
  bit m_run, m_busy, m_ack, m_err;

  always #5 clock_in = ~clock_in;

  clk_div_ctrl dut (
    .clock_in      (clock_in),
    .reset         (reset),
    .enable        (enable),
    .div_req       (div_req),
    .div_value     (div_value),
    .div_ack       (div_ack),
    .div_err       (div_err),
    .div_busy      (div_busy),
    .div_active    (div_active),
    .clock_out_div (clock_out_div),
    .period_tick   (period_tick),
    .dbg_state_o   (dbg_state_o)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Output level at half-cycle hp of the current period: D half-cycles high,
  // starting at the period's posedge for even D, half a cycle later for odd D.
  function automatic int exp_clk(input int hp);
    if (!m_run) return 0;
    if (m_d % 2 == 0) return (hp < m_d) ? 1 : 0;
    return (hp >= 1 && hp <= m_d) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_d = 2; m_pos = 0; m_pend = 0;
    m_run = 0; m_busy = 0; m_ack = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit en, input bit req, input int val);
    bit at_end;
    at_end = m_run && (m_pos == m_d - 1);
    m_ack  = 0;
    m_err  = 0;
    if (m_busy) begin
      if (!m_run || at_end) begin
        m_d    = m_pend;
        m_busy = 0;
        m_ack  = 1;
      end
    end else if (req) begin
      if (val >= 2) begin
        m_pend = val;
        m_busy = 1;
      end else begin
        m_err = 1;
      end
    end
    if (!m_run || at_end) begin
      m_pos = 0;
      m_run = en;
    end else begin
      m_pos++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".ack"},    div_ack, 0);
    check_eq({tag, ".err"},    div_err, 0);
    check_eq({tag, ".busy"},   div_busy, 0);
    check_eq({tag, ".tick"},   period_tick, 0);
    check_eq({tag, ".clk"},    clock_out_div, 0);
    check_eq({tag, ".active"}, div_active, 2);
    check_eq({tag, ".state"},  dbg_state_o, 0);
  endtask

  task automatic do_reset();
    div_req = 1'b0;
    reset   = 1'b1;
    #1;
    check_reset_vals("rst_now");
    repeat (2) @(posedge clock_in);
    #1;
    check_reset_vals("rst_hold");
    @(negedge clock_in);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic step(input bit en, input bit req, input logic [3:0] val);
    enable    = en;
    div_req   = req;
    div_value = val;
    @(posedge clock_in);
    #1;
    model_edge(en, req, int'(val));
    check_eq("active", div_active, m_d);
    check_eq("busy",   div_busy, m_busy);
    check_eq("state",  dbg_state_o, m_busy);
    check_eq("ack",    div_ack, m_ack);
    check_eq("err",    div_err, m_err);
    check_eq("tick_p", period_tick, (m_pos == m_d - 1 && en) ? 1 : 0);
    check_eq("clk_p",  clock_out_div, exp_clk(2 * m_pos));
    @(negedge clock_in);
    #1;
    check_eq("clk_n",  clock_out_div, exp_clk(2 * m_pos + 1));
    check_eq("tick_n", period_tick, (m_pos == m_d - 1 && en) ? 1 : 0);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int low_left;
    bit en_r, req_r;
    model_reset();
    #1;
    do_reset();

    idle_steps(10);                 // D=2 free run
    step(1'b1, 1'b1, 4'd4);
    idle_steps(14);
    step(1'b1, 1'b1, 4'd5);
    idle_steps(16);
    step(1'b1, 1'b1, 4'd1);         // illegal requests
    idle_steps(3);
    step(1'b1, 1'b1, 4'd0);
    idle_steps(6);
    step(1'b1, 1'b1, 4'd15);        // second request while busy is dropped
    step(1'b1, 1'b1, 4'd3);
    idle_steps(40);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd6);         // applied while parked
    idle_steps(3);
    idle_steps(20);
    step(1'b1, 1'b1, 4'd7);
    idle_steps(20);
    step(1'b1, 1'b1, 4'd9);         // pending at D=7, then reset
    do_reset();
    idle_steps(8);

    low_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (low_left == 0 && $urandom_range(0, 149) == 0) low_left = $urandom_range(2, 25);
      en_r = (low_left == 0);
      if (low_left > 0) low_left--;
      req_r = ($urandom_range(0, 7) == 0);
      step(en_r, req_r, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 699) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
